// File: rtl/qdr_burst_host_bridge_if.sv
// Host register bus plus QDR request/ack port, bundled for the burst bridge.
// slave = bridge side, master = host decode / QDR arbiter side.
interface qdr_burst_host_bridge_if #(
  parameter int HOST_DW = 32,
  parameter int ADDR_W  = 32
);
  localparam int QDR_DW = 9 * HOST_DW / 8;

  logic                 host_en;
  logic                 host_rnw;
  logic [ADDR_W-1:0]    host_addr;
  logic [HOST_DW-1:0]   host_datai;
  logic [HOST_DW/8-1:0] host_be;
  logic [HOST_DW-1:0]   host_datao;
  logic                 host_ack;
  logic                 host_err;
  logic                 host_perr;
  logic                 host_busy;
  logic                 qdr_req;
  logic                 qdr_ack;
  logic [ADDR_W-1:0]    qdr_addr;
  logic                 qdr_r;
  logic                 qdr_w;
  logic [QDR_DW-1:0]    qdr_d;
  logic [HOST_DW/8-1:0] qdr_be;
  logic [QDR_DW-1:0]    qdr_q;

  modport slave (
    input  host_en, host_rnw, host_addr, host_datai, host_be, qdr_ack, qdr_q,
    output host_datao, host_ack, host_err, host_perr, host_busy,
           qdr_req, qdr_addr, qdr_r, qdr_w, qdr_d, qdr_be
  );

  modport master (
    output host_en, host_rnw, host_addr, host_datai, host_be, qdr_ack, qdr_q,
    input  host_datao, host_ack, host_err, host_perr, host_busy,
           qdr_req, qdr_addr, qdr_r, qdr_w, qdr_d, qdr_be
  );
endinterface

// File: rtl/qdr_burst_host_bridge.sv
// Host register bus to QDR request/ack bridge: each host access becomes one QDR
// burst whose addressed beat carries the host byte enables / read data.
module qdr_burst_host_bridge #(
  parameter int HOST_DW     = 32,
  parameter int ADDR_W      = 32,
  parameter int BURST_LEN   = 2,
  parameter int QDR_LATENCY = 10,
  parameter int PARITY_EN   = 0,
  parameter int TIMEOUT     = 255
) (
  input logic                    qdr_clk,
  input logic                    qdr_rst_n,
  qdr_burst_host_bridge_if.slave bus
);
  localparam int unsigned NB = HOST_DW / 8;
  localparam int QDR_DW      = 9 * HOST_DW / 8;
  localparam int B           = $clog2(NB);
  localparam int S           = $clog2(BURST_LEN);
  localparam int LAT_W       = $clog2(QDR_LATENCY + BURST_LEN + 1);
  localparam logic [S-1:0]     BEAT_LAST = S'(BURST_LEN - 1);
  localparam logic [LAT_W-1:0] LAT_BASE  = LAT_W'(QDR_LATENCY);
  localparam logic [15:0]      TO_LIMIT  = 16'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, BEAT, RWAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [HOST_DW-1:0] data_q, data_d;
  logic [HOST_DW-1:0] datao_q, datao_d;
  logic [NB-1:0]      be_q, be_d;
  logic               rnw_q, rnw_d;
  logic               err_q, err_d;
  logic               perr_q, perr_d;
  logic [15:0]        to_q, to_d;
  logic [S-1:0]       beat_q, beat_d;
  logic [LAT_W-1:0]   lat_q, lat_d;

  logic [S-1:0]       sel;
  logic [LAT_W-1:0]   lat_tgt;
  logic [QDR_DW-1:0]  wr_lanes;
  logic [HOST_DW-1:0] rd_bytes;
  logic               rd_perr;
  logic               req;
  logic [NB-1:0]      be_out;
  logic [QDR_DW-1:0]  d_out;

  assign sel     = addr_q[B+S-1:B];
  assign lat_tgt = LAT_BASE + LAT_W'(sel);

  // Lane packing: 9-bit lanes, byte in the low 8 bits, parity (or 0) on top.
  always_comb begin
    wr_lanes = '0;
    rd_bytes = '0;
    rd_perr  = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      wr_lanes[9*i +: 8]  = data_q[8*i +: 8];
      wr_lanes[9*i + 8]   = (PARITY_EN != 0) && (^data_q[8*i +: 8]);
      rd_bytes[8*i +: 8]  = bus.qdr_q[9*i +: 8];
      if ((PARITY_EN != 0) && (bus.qdr_q[9*i + 8] != ^bus.qdr_q[9*i +: 8]))
        rd_perr = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    datao_d = datao_q;
    be_d    = be_q;
    rnw_d   = rnw_q;
    err_d   = err_q;
    perr_d  = perr_q;
    to_d    = to_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    req     = 1'b0;
    be_out  = '0;
    d_out   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.host_en) begin
          addr_d  = bus.host_addr;
          data_d  = bus.host_datai;
          be_d    = bus.host_be;
          rnw_d   = bus.host_rnw;
          to_d    = '0;
          lat_d   = '0;
          err_d   = 1'b0;
          perr_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (to_q == TO_LIMIT) begin
          err_d   = 1'b1;
          datao_d = '0;
          state_d = DONE;
        end else begin
          req   = 1'b1;
          d_out = wr_lanes;
          if (sel == '0) be_out = be_q;
          if (bus.qdr_ack) begin
            beat_d  = S'(1);
            lat_d   = LAT_W'(1);
            state_d = BEAT;
          end else begin
            to_d = to_q + 16'd1;
          end
        end
      end
      BEAT: begin
        d_out = wr_lanes;
        if (beat_q == sel) be_out = be_q;
        lat_d = lat_q + LAT_W'(1);
        // Short latencies can land the read beat before the burst ends, so
        // capture is allowed here and RWAIT is skipped once it has happened.
        if (rnw_q && (lat_q == lat_tgt)) begin
          datao_d = rd_bytes;
          perr_d  = rd_perr;
        end
        if (beat_q == BEAT_LAST) begin
          if (!rnw_q || (lat_q >= lat_tgt)) state_d = DONE;
          else                             state_d = RWAIT;
        end else begin
          beat_d = beat_q + S'(1);
        end
      end
      RWAIT: begin
        lat_d = lat_q + LAT_W'(1);
        if (lat_q == lat_tgt) begin
          datao_d = rd_bytes;
          perr_d  = rd_perr;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      datao_q <= '0;
      be_q    <= '0;
      rnw_q   <= 1'b0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
      to_q    <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      datao_q <= datao_d;
      be_q    <= be_d;
      rnw_q   <= rnw_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
      to_q    <= to_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  assign bus.host_datao = datao_q;
  assign bus.host_ack   = (state_q == DONE);
  assign bus.host_err   = (state_q == DONE) && err_q;
  assign bus.host_perr  = (state_q == DONE) && perr_q;
  assign bus.host_busy  = (state_q != IDLE);
  assign bus.qdr_req    = req;
  assign bus.qdr_r      = req && rnw_q;
  assign bus.qdr_w      = req && !rnw_q;
  assign bus.qdr_addr   = addr_q >> (B + S);
  assign bus.qdr_d      = d_out;
  assign bus.qdr_be     = be_out;
endmodule
